// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues word fetches, reserves a queue slot for every
// in-flight request, buffers in-order responses with their PCs and flushes on redirect.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    logic [CNT_W:0]   credits_used;
    logic             req_fire;
    logic             resp_live;
    logic             resp_keep;
    logic             resp_drop;
    logic             deq;
    logic [31:0]      redirect_base;

    // A slot is reserved at request time, so queued plus in-flight never exceeds DEPTH.
    assign credits_used   = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_valid = !reset && (credits_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;

    assign inst_valid = (count_q != '0);
    assign inst       = mem_q[rd_ptr_q].data;
    assign inst_pc    = mem_q[rd_ptr_q].pc;

    assign req_fire      = imem_req_valid && imem_req_ready;
    assign resp_live     = imem_resp_valid && (outstanding_q != '0);
    assign resp_drop     = resp_live && (discard_q != '0);
    assign resp_keep     = resp_live && (discard_q == '0);
    assign deq           = inst_valid && inst_ready;
    assign redirect_base = {redirect_pc[31:2], 2'b00};

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path through this block can infer a latch.
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        mem_d         = mem_q;

        if (req_fire && !resp_live) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!req_fire && resp_live) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (redirect_valid) begin
            // Everything requested before the redirect is stale, including this cycle's accept.
            fetch_pc_d = redirect_base;
            resp_pc_d  = redirect_base;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_drop) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (resp_keep) begin
                mem_d[wr_ptr_q] = {imem_resp_data, resp_pc_q};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                resp_pc_d       = resp_pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({resp_keep, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            // NOTE: queue storage is cleared as well so inst/inst_pc read zero straight out of reset.
            mem_q         <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            mem_q         <= mem_d;
        end
    end

    a_credit_bound: assert property (@(posedge clk) disable iff (reset) credits_used <= DEPTH_W);
    a_discard_bound: assert property (@(posedge clk) disable iff (reset) discard_q <= outstanding_q);

endmodule

// File: tb/tb_fetch_controller.sv
// Randomised scoreboard bench for fetch_controller: a behavioural memory plus an
// epoch-based model of the decode stream predicts every instruction handed to decode.
module tb_fetch_controller;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_controller #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // addr: what memory saw; pc: where the model says the fetch should have been.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int unsigned epoch;
        int unsigned due;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    req_t        pending[$];
    exp_t        sb[$];
    logic [31:0] acc_addr[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    exp_t        mon_e;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned epoch    = 0;
    logic [31:0] exp_addr = RESET_PC;

    // Stimulus knobs; modes: 0 = drive 1, 1 = drive 0, 2 = random.
    bit          drv_reset    = 1'b1;
    int          ready_mode   = 0;
    int          ir_mode      = 0;
    int unsigned lat_min      = 1;
    int unsigned lat_max      = 1;
    bit          redir_pend   = 1'b0;
    logic [31:0] redir_pc     = '0;
    bit          collide_pend = 1'b0;
    logic [31:0] collide_pc   = '0;
    bit          rand_redir   = 1'b0;
    bit          straggler    = 1'b0;

    bit          mark      = 1'b0;
    bit          mark_seen = 1'b0;
    logic [31:0] mark_pc   = '0;
    logic [31:0] mark_inst = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Reference model for one clock cycle, evaluated just before the active edge.
    task automatic ref_model_cycle();
        req_t r;
        if (reset) begin
            check("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
            sb.delete();
            pending.delete();
            epoch++;
            exp_addr = RESET_PC;
            return;
        end
        check("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
        check("req_valid", 32'(imem_req_valid), 32'((sb.size() + pending.size()) < DEPTH));
        if (imem_resp_valid && pending.size() > 0) begin
            r = pending.pop_front();
            if (r.epoch == epoch && !redirect_valid) begin
                sb.push_back('{data: mem_word(r.pc), pc: r.pc});
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_addr);
            r.addr  = imem_req_addr;
            r.pc    = exp_addr;
            r.epoch = epoch;
            r.due   = cyc + $urandom_range(lat_max, lat_min);
            pending.push_back(r);
            acc_addr.push_back(imem_req_addr);
            exp_addr = exp_addr + 32'd4;
        end
        if (redirect_valid) begin
            epoch++;
            sb.delete();
            exp_addr = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        reset           = drv_reset;
        imem_req_ready  = pick(ready_mode);
        inst_ready      = pick(ir_mode);
        redirect_valid  = 1'b0;
        redirect_pc     = $urandom();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom();
        if (straggler) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
            straggler       = 1'b0;
        end else if (!drv_reset && pending.size() > 0 && pending[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pending[0].addr);
        end
        #1;
        if (!drv_reset) begin
            if (redir_pend) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_pc;
                redir_pend     = 1'b0;
                mark           = 1'b1;
                mark_seen      = 1'b0;
            end else if (collide_pend && imem_req_valid && imem_req_ready && imem_resp_valid) begin
                redirect_valid = 1'b1;
                redirect_pc    = collide_pc;
                collide_pend   = 1'b0;
                mark           = 1'b1;
                mark_seen      = 1'b0;
            end else if (rand_redir && $urandom_range(15, 0) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom();
            end
        end
        #1;
        ref_model_cycle();
    endtask

    task automatic do_reset();
        drv_reset = 1'b1;
        step();
        step();
        drv_reset = 1'b0;
    endtask

    task automatic clear_hist();
        acc_addr.delete();
        pop_pc.delete();
        pop_inst.delete();
    endtask

    // Monitor: pops the scoreboard whenever decode takes an instruction.
    always begin
        @(negedge clk);
        #3;
        if (!reset && !redirect_valid && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_inst: got inst 0x%08h pc 0x%08h, expected no instruction (cycle %0d)",
                         inst, inst_pc, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("inst", inst, mon_e.data);
                check("inst_pc", inst_pc, mon_e.pc);
                pop_pc.push_back(inst_pc);
                pop_inst.push_back(inst);
                if (mark && !mark_seen) begin
                    mark_seen = 1'b1;
                    mark_pc   = inst_pc;
                    mark_inst = inst;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b0;

        // Basic stream after reset, latency 1, decoder always ready.
        do_reset();
        ready_mode = 0;
        ir_mode    = 0;
        lat_min    = 1;
        lat_max    = 1;
        clear_hist();
        step();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_first_req_valid", 32'(imem_req_valid), 32'd1);
        repeat (8) step();
        if (pop_inst.size() >= 2 && acc_addr.size() >= 2) begin
            check("s1_addr0", acc_addr[0], 32'h0);
            check("s1_addr1", acc_addr[1], 32'h4);
            check("s1_inst0", pop_inst[0], 32'h0050_0093);
            check("s1_pc0", pop_pc[0], 32'h0);
            check("s1_inst1", pop_inst[1], 32'h00A0_0113);
            check("s1_pc1", pop_pc[1], 32'h4);
        end else begin
            timeout_fail("s1_stream");
        end

        // Decoder stalled: credits stop fetch at DEPTH, then one pop per cycle.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        ir_mode = 1;
        clear_hist();
        repeat (10) step();
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_inst_valid", 32'(inst_valid), 32'd1);
        check("stall_accepts", 32'(acc_addr.size()), 32'd2);
        ir_mode = 0;
        step();
        step();
        step();
        check("one_pop_per_cycle", 32'(pop_pc.size()), 32'd2);
        if (pop_pc.size() >= 2) begin
            check("stall_pop_pc0", pop_pc[0], 32'h0);
            check("stall_pop_pc1", pop_pc[1], 32'h4);
        end

        // Redirect with two requests in flight.
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (pending.size() == 2) ok = 1'b1;
            else step();
        end
        if (ok) begin
            check("inflight0", pending[0].addr, 32'h8);
            check("inflight1", pending[1].addr, 32'hC);
            redir_pend = 1'b1;
            redir_pc   = 32'h0000_0100;
            step();
            step();
            check("post_redirect_inst_valid", 32'(inst_valid), 32'd0);
            repeat (15) step();
            check("redir_seen", 32'(mark_seen), 32'd1);
            check("redir_pc", mark_pc, 32'h100);
            check("redir_inst", mark_inst, mem_word(32'h100));
        end else begin
            timeout_fail("two_in_flight");
        end

        // Redirect colliding with a request accept and a response arrival.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        ready_mode = 0;
        ir_mode = 0;
        collide_pend = 1'b1;
        collide_pc   = 32'h0000_0202;
        for (int i = 0; i < 20 && collide_pend; i++) step();
        if (collide_pend) begin
            collide_pend = 1'b0;
            timeout_fail("collision");
        end else begin
            repeat (12) step();
            check("coll_seen", 32'(mark_seen), 32'd1);
            check("coll_pc", mark_pc, 32'h200);
            check("coll_inst", mark_inst, mem_word(32'h200));
        end

        // Random traffic: ready toggling, latency 1-3, random decoder stalls and redirects.
        do_reset();
        ready_mode = 2;
        ir_mode    = 2;
        lat_min    = 1;
        lat_max    = 3;
        rand_redir = 1'b1;
        clear_hist();
        repeat (3000) step();
        rand_redir = 1'b0;
        check("random_progress", 32'(pop_pc.size() > 200), 32'd1);

        // Reset with the credits exhausted: one queued, one in flight.
        ready_mode = 1;
        ir_mode    = 0;
        for (int i = 0; i < 50 && (pending.size() != 0 || sb.size() != 0); i++) step();
        lat_min    = 3;
        lat_max    = 3;
        ready_mode = 0;
        ir_mode    = 1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (sb.size() == 1 && pending.size() == 1) ok = 1'b1;
        end
        if (!ok) timeout_fail("fill_before_reset");
        do_reset();
        ready_mode = 1;
        ir_mode    = 0;
        straggler  = 1'b1;
        step();
        check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_inst", inst, 32'd0);
        check("mid_rst_inst_pc", inst_pc, 32'd0);
        check("mid_rst_req_addr", imem_req_addr, RESET_PC);
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd1);
        step();
        check("straggler_ignored", 32'(inst_valid), 32'd0);
        ready_mode = 0;
        mark       = 1'b1;
        mark_seen  = 1'b0;
        repeat (10) step();
        check("mid_rst_first_pc", mark_pc, RESET_PC);
        check("mid_rst_first_inst", mark_inst, mem_word(RESET_PC));

        // Drain: everything the model expects must have reached decode.
        ready_mode = 1;
        ir_mode    = 0;
        for (int i = 0; i < 50 && (pending.size() != 0 || sb.size() != 0); i++) step();
        step();
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_inst_valid", 32'(inst_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
